// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer.
//   CNT_W   : width of the downstream up/down counter (Q and D).
//   state_e : sequencer FSM states.
package counter_seq_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    FINISH = 3'd3,
    ABORT  = 3'd4
  } state_e;

endpackage

// File: rtl/counter_sequencer_if.sv
// Signal bundle between a command issuer, the counter sequencer and the
// 4-bit up/down counter it controls.
//   cmd_*      : command handshake and fields (issuer -> sequencer, ready back)
//   cnt_*      : counter control outputs and counter status inputs
//   done       : one-cycle pulse on normal completion
//   aborted    : one-cycle pulse on abort completion
//   wrap_count : wraps seen in the current/last command
//   dbg_state  : sequencer FSM state, for observation only
// Modports: slave = the sequencer, master = everything around it.
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready is only high while the sequencer is
// idle; the issuer must hold the command fields stable while cmd_valid is
// high and not yet accepted.
interface counter_sequencer_if #(
  parameter int WRAPS_W = 8
);
  import counter_seq_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_down;
  logic [CNT_W-1:0]   cmd_start;
  logic [WRAPS_W-1:0] cmd_wraps;
  logic               cmd_abort;

  logic               cnt_clear;
  logic               cnt_load;
  logic               cnt_enable;
  logic               cnt_down;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               cnt_overflow;

  logic               done;
  logic               aborted;
  logic [WRAPS_W-1:0] wrap_count;
  state_e             dbg_state;

  modport slave (
    input  cmd_valid, cmd_down, cmd_start, cmd_wraps, cmd_abort,
    input  cnt_q, cnt_overflow,
    output cmd_ready,
    output cnt_clear, cnt_load, cnt_enable, cnt_down, cnt_d,
    output done, aborted, wrap_count, dbg_state
  );

  modport master (
    output cmd_valid, cmd_down, cmd_start, cmd_wraps, cmd_abort,
    output cnt_q, cnt_overflow,
    input  cmd_ready,
    input  cnt_clear, cnt_load, cnt_enable, cnt_down, cnt_d,
    input  done, aborted, wrap_count, dbg_state
  );

endinterface

// File: rtl/counter_sequencer.sv
// Command-driven controller for a 4-bit up/down counter. Accepts a start
// value, direction and wrap count, loads the counter, counts its OVERFLOW
// pulses and stops it exactly on the final wrap, then pulses DONE. An abort
// during LOAD/RUN clears the counter and pulses ABORTED instead.
// Ports:
//   CLK : clock, all state on rising edge
//   RST : asynchronous active-low reset
//   bus : counter_sequencer_if slave (command, counter control, status)
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WRAPS_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  counter_sequencer_if.slave  bus
);

  state_e             state_q, state_d;
  logic               ready_q, ready_d;
  logic               down_q, down_d;
  logic [CNT_W-1:0]   start_q, start_d;
  logic [WRAPS_W-1:0] target_q, target_d;
  logic [WRAPS_W-1:0] wrap_count_q, wrap_count_d;

  logic               final_wrap;
  logic               cnt_clear_c, cnt_load_c, cnt_enable_c, cnt_down_c;
  logic [CNT_W-1:0]   cnt_d_c;
  logic               done_c, aborted_c;

  // The overflow now arriving is the last one wanted. target_q is never 0
  // while in RUN, so target-1 does not underflow there.
  assign final_wrap = bus.cnt_overflow &&
                      (wrap_count_q == (target_q - WRAPS_W'(1)));

  always_comb begin
    state_d      = state_q;
    down_d       = down_q;
    start_d      = start_q;
    target_d     = target_q;
    wrap_count_d = wrap_count_q;
    cnt_clear_c  = 1'b0;
    cnt_load_c   = 1'b0;
    cnt_enable_c = 1'b0;
    cnt_down_c   = 1'b0;
    cnt_d_c      = '0;
    done_c       = 1'b0;
    aborted_c    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          down_d       = bus.cmd_down;
          start_d      = bus.cmd_start;
          target_d     = bus.cmd_wraps;
          wrap_count_d = '0;
          // A zero-wrap command completes without touching the counter.
          state_d      = (bus.cmd_wraps == '0) ? FINISH : LOAD;
        end
      end
      LOAD: begin
        cnt_load_c = 1'b1;
        cnt_d_c    = start_q;
        cnt_down_c = down_q;
        state_d    = bus.cmd_abort ? ABORT : RUN;
      end
      RUN: begin
        cnt_down_c   = down_q;
        // Dropping enable in the same cycle as the final overflow parks the
        // counter on its wrapped value (0 up, 15 down).
        cnt_enable_c = !final_wrap;
        if (bus.cmd_abort) begin
          state_d = ABORT;
        end else if (bus.cnt_overflow) begin
          wrap_count_d = (&wrap_count_q) ? wrap_count_q
                                         : wrap_count_q + WRAPS_W'(1);
          if (final_wrap) state_d = FINISH;
        end
      end
      FINISH: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      ABORT: begin
        cnt_clear_c = 1'b1;
        aborted_c   = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered ready: high exactly in cycles whose state is IDLE, but held
    // low during reset and for the first cycle after release.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      down_q       <= 1'b0;
      start_q      <= '0;
      target_q     <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      down_q       <= down_d;
      start_q      <= start_d;
      target_q     <= target_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign bus.cmd_ready  = ready_q;
  assign bus.cnt_clear  = cnt_clear_c;
  assign bus.cnt_load   = cnt_load_c;
  assign bus.cnt_enable = cnt_enable_c;
  assign bus.cnt_down   = cnt_down_c;
  assign bus.cnt_d      = cnt_d_c;
  assign bus.done       = done_c;
  assign bus.aborted    = aborted_c;
  assign bus.wrap_count = wrap_count_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer with a behavioural 4-bit up/down counter
// attached. Expected completion cycle, wrap count and final counter value
// of every command come from closed-form timing arithmetic.
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  localparam int WRAPS_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  counter_sequencer_if #(.WRAPS_W(WRAPS_W)) bus();

  counter_sequencer #(.WRAPS_W(WRAPS_W)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  // Behavioural counter: clear > load > enable; OVERFLOW is a registered
  // pulse in the cycle after a wrapping step.
  logic [3:0] ctr_q;
  logic       ctr_ovf;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr_q   <= 4'd0;
      ctr_ovf <= 1'b0;
    end else if (bus.cnt_clear) begin
      ctr_q   <= 4'd0;
      ctr_ovf <= 1'b0;
    end else if (bus.cnt_load) begin
      ctr_q   <= bus.cnt_d;
      ctr_ovf <= 1'b0;
    end else if (bus.cnt_enable) begin
      ctr_q   <= bus.cnt_down ? ctr_q - 4'd1 : ctr_q + 4'd1;
      ctr_ovf <= bus.cnt_down ? (ctr_q == 4'd0) : (ctr_q == 4'd15);
    end else begin
      ctr_ovf <= 1'b0;
    end
  end
  assign bus.cnt_q        = ctr_q;
  assign bus.cnt_overflow = ctr_ovf;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  last_q;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},   bus.cmd_ready, 0);
    check({tag, "_done"},    bus.done, 0);
    check({tag, "_aborted"}, bus.aborted, 0);
    check({tag, "_load"},    bus.cnt_load, 0);
    check({tag, "_enable"},  bus.cnt_enable, 0);
    check({tag, "_clear"},   bus.cnt_clear, 0);
    check({tag, "_down"},    bus.cnt_down, 0);
    check({tag, "_d"},       bus.cnt_d, 0);
    check({tag, "_wraps"},   bus.wrap_count, 0);
  endtask

  // Last cycle (relative to accept at cycle 0) in which a command with
  // start s, direction down and n>0 wraps sees its final overflow.
  function automatic int final_cycle(input logic down, input logic [3:0] s,
                                     input int n);
    int f;
    f = down ? int'(s) + 1 : 16 - int'(s);
    return (n == 0) ? 0 : 2 + f + 16 * (n - 1);
  endfunction

  // ---------------- driver ----------------
  task automatic run_cmd(input logic down, input logic [3:0] s, input int n,
                         input int abort_at);
    int f, final_c, end_c, exp_wraps, guard;
    logic exp_abort;
    logic [3:0] exp_qv;
    int done_c, abrt_c, n_done, n_abrt, n_bad_load, n_en;
    logic load_c1, clear_end;
    logic [31:0] e_end, e_wraps, e_q;

    f         = down ? int'(s) + 1 : 16 - int'(s);
    final_c   = final_cycle(down, s, n);
    exp_abort = (n > 0) && (abort_at >= 1) && (abort_at <= final_c);
    if (exp_abort) begin
      end_c     = abort_at + 1;
      exp_wraps = 0;
      for (int j = 0; j < n; j++)
        if (2 + f + 16 * j < abort_at) exp_wraps++;
      exp_qv = 4'd0;
    end else begin
      end_c     = (n == 0) ? 1 : final_c + 1;
      exp_wraps = n;
      exp_qv    = (n == 0) ? last_q : (down ? 4'd15 : 4'd0);
    end

    guard = 0;
    while (!bus.cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_wait", bus.cmd_ready, 1);

    exp_q.push_back(end_c);
    exp_q.push_back(exp_wraps);
    exp_q.push_back(exp_qv);

    // cycle 0: present the command
    bus.cmd_valid = 1'b1;
    bus.cmd_down  = down;
    bus.cmd_start = s;
    bus.cmd_wraps = WRAPS_W'(n);

    done_c = -1; abrt_c = -1; n_done = 0; n_abrt = 0;
    n_bad_load = 0; n_en = 0; load_c1 = 1'b0; clear_end = 1'b0;

    for (int t = 1; t <= end_c + 1; t++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      if (bus.done)    begin n_done++; done_c = t; end
      if (bus.aborted) begin n_abrt++; abrt_c = t; end
      if (bus.cnt_enable) n_en++;
      if (t == 1) begin
        load_c1 = bus.cnt_load;
        check("ready_low_c1", bus.cmd_ready, 0);
      end else if (bus.cnt_load) begin
        n_bad_load++;
      end
      if (t == end_c) clear_end = bus.cnt_clear;
      if (n > 0 && t == final_c && (!exp_abort || abort_at == final_c)) begin
        check("final_ovf", bus.cnt_overflow, 1);
        check("final_enable", bus.cnt_enable, 0);
      end
      if (t == end_c + 1) begin
        e_end   = exp_q.pop_front();
        e_wraps = exp_q.pop_front();
        e_q     = exp_q.pop_front();
        check("ready_after", bus.cmd_ready, 1);
        check("wrap_count", bus.wrap_count, e_wraps);
        check("cnt_q", bus.cnt_q, e_q);
        if (exp_abort) begin
          check("aborted_cycle", abrt_c, e_end);
          check("aborted_pulses", n_abrt, 1);
          check("done_pulses", n_done, 0);
          check("clear_in_abort", clear_end, 1);
        end else begin
          check("done_cycle", done_c, e_end);
          check("done_pulses", n_done, 1);
          check("aborted_pulses", n_abrt, 0);
        end
      end
      bus.cmd_abort = (t == abort_at);
    end
    bus.cmd_abort = 1'b0;

    check("load_c1", load_c1, (n > 0) ? 1 : 0);
    check("load_extra", n_bad_load, 0);
    if (n == 0) check("enable_zero_wraps", n_en, 0);
    last_q = exp_qv;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_down  = 1'b0;
    bus.cmd_start = 4'd0;
    bus.cmd_wraps = '0;
    bus.cmd_abort = 1'b0;
    last_q        = 4'd0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_state", bus.dbg_state, IDLE);
    rst_n = 1'b1;
    #1;
    check("ready_at_release", bus.cmd_ready, 0);
    @(negedge clk);
    check("ready_after_release", bus.cmd_ready, 1);

    run_cmd(1'b0, 4'd14, 1, 0);
    run_cmd(1'b1, 4'd2, 3, 0);
    run_cmd(1'b0, 4'd5, 0, 0);
    run_cmd(1'b0, 4'd0, 4, 20);
    run_cmd(1'b0, 4'd10, 2, final_cycle(1'b0, 4'd10, 2));
    run_cmd(1'b1, 4'd9, 1, 1);
    run_cmd(1'b1, 4'd0, 2, final_cycle(1'b1, 4'd0, 2) + 1);

    for (int k = 0; k < 14; k++) begin
      logic       rd;
      logic [3:0] rs;
      int         rn, ra, fc;
      rd = 1'($urandom_range(0, 1));
      rs = 4'($urandom_range(0, 15));
      rn = $urandom_range(0, 3);
      fc = final_cycle(rd, rs, rn);
      ra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, fc + 2) : 0;
      run_cmd(rd, rs, rn, ra);
    end

    // asynchronous reset in the middle of a run
    while (!bus.cmd_ready) @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_down  = 1'b0;
    bus.cmd_start = 4'd3;
    bus.cmd_wraps = WRAPS_W'(2);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk);
    check("midrun_reset_done", bus.done, 0);
    check("midrun_reset_aborted", bus.aborted, 0);
    rst_n = 1'b1;
    #1;
    check("midrun_release_ready", bus.cmd_ready, 0);
    @(negedge clk);
    check("midrun_ready_back", bus.cmd_ready, 1);
    last_q = 4'd0;
    run_cmd(1'b1, 4'd7, 2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
